// File: rtl/vector.sv
// Registered bitwise/logical/reduction OR and inversion of two operands.
// One-cycle latency, one result per accepted input, no input-to-output paths.
module vector #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [WIDTH-1:0]   a_bitwise_or_b,
  output logic               a_logical_or_b,
  output logic               a_reduction_or,
  output logic               b_reduction_or,
  output logic [2*WIDTH-1:0] not_a_not_b
);

  logic [WIDTH-1:0]   or_d;
  logic               ra_d;
  logic               rb_d;
  logic [2*WIDTH-1:0] not_d;

  always_comb begin
    or_d  = a | b;
    ra_d  = |a;
    rb_d  = |b;
    not_d = {~b, ~a};
  end

  // Results only load on accepted input; out_valid tracks in_valid every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      a_bitwise_or_b <= '0;
      a_logical_or_b <= 1'b0;
      a_reduction_or <= 1'b0;
      b_reduction_or <= 1'b0;
      not_a_not_b    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        a_bitwise_or_b <= or_d;
        a_logical_or_b <= ra_d | rb_d;
        a_reduction_or <= ra_d;
        b_reduction_or <= rb_d;
        not_a_not_b    <= not_d;
      end
    end
  end

endmodule

// File: tb/tb_vector.sv
// Scoreboard bench for vector at WIDTH=4 and WIDTH=8.
// Expected results queued at drive time, popped when out_valid is due.
module tb_vector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv4, iv8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;

  logic       ov4, lo4, ra4, rb4;
  logic [3:0] or4;
  logic [7:0] n4;
  logic       ov8, lo8, ra8, rb8;
  logic [7:0] or8;
  logic [15:0] n8;

  vector #(.WIDTH(4)) d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .a(a4), .b(b4),
    .out_valid(ov4), .a_bitwise_or_b(or4), .a_logical_or_b(lo4),
    .a_reduction_or(ra4), .b_reduction_or(rb4), .not_a_not_b(n4)
  );

  vector #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8),
    .out_valid(ov8), .a_bitwise_or_b(or8), .a_logical_or_b(lo8),
    .a_reduction_or(ra8), .b_reduction_or(rb8), .not_a_not_b(n8)
  );

  typedef struct packed {
    logic        v;
    logic [7:0]  o;
    logic        l;
    logic        ra;
    logic        rb;
    logic [15:0] n;
  } r_t;

  r_t q4[$];
  r_t q8[$];
  r_t last4, last8;
  int checks = 0;
  int errors = 0;

  function automatic r_t model(int w, logic [7:0] a, logic [7:0] b);
    r_t r;
    r = '0;
    r.v = 1'b1;
    for (int i = 0; i < w; i++) begin
      r.o[i]     = a[i] | b[i];
      r.ra       = r.ra | a[i];
      r.rb       = r.rb | b[i];
      r.n[i]     = ~a[i];
      r.n[w + i] = ~b[i];
    end
    r.l = (r.o != 8'h00);
    return r;
  endfunction

  function automatic r_t obs4();
    r_t r;
    r = '0;
    r.v = ov4;
    r.o[3:0] = or4;
    r.l = lo4;
    r.ra = ra4;
    r.rb = rb4;
    r.n[7:0] = n4;
    return r;
  endfunction

  function automatic r_t obs8();
    r_t r;
    r.v = ov8;
    r.o = or8;
    r.l = lo8;
    r.ra = ra8;
    r.rb = rb8;
    r.n = n8;
    return r;
  endfunction

  task automatic test_reset();
    r_t g;
    rst_n = 1'b0;
    iv4 = 1'b1; a4 = 4'hf; b4 = 4'hf;
    iv8 = 1'b1; a8 = 8'hff; b8 = 8'hff;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      g = obs4();
      checks++;
      if (g !== r_t'(0)) begin
        errors++;
        $display("FAIL reset_w4 cyc%0d got=%h exp=0", c, g);
      end
      g = obs8();
      checks++;
      if (g !== r_t'(0)) begin
        errors++;
        $display("FAIL reset_w8 cyc%0d got=%h exp=0", c, g);
      end
    end
    rst_n = 1'b1;
    iv4 = 1'b0;
    iv8 = 1'b0;
    last4 = '0;
    last8 = '0;
  endtask

  task automatic test_directed();
    logic [3:0] at [6] = '{4'h0, 4'h0, 4'h5, 4'h5, 4'h5, 4'hf};
    logic [3:0] bt [6] = '{4'h0, 4'h3, 4'h0, 4'h3, 4'ha, 4'hf};
    logic [7:0] nt [6] = '{8'hff, 8'hcf, 8'hfa, 8'hca, 8'h5a, 8'h00};
    logic [3:0] ot [6] = '{4'h0, 4'h3, 4'h5, 4'h7, 4'hf, 4'hf};
    r_t e, g;
    for (int i = 0; i < 6; i++) begin
      iv4 = 1'b1;
      a4 = at[i];
      b4 = bt[i];
      q4.push_back(model(4, {4'h0, at[i]}, {4'h0, bt[i]}));
      @(posedge clk); #1;
      e = q4.pop_front();
      last4 = e;
      g = obs4();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL directed%0d got=%h exp=%h", i, g, e);
      end
      checks++;
      if (g.n[7:0] !== nt[i] || g.o[3:0] !== ot[i]) begin
        errors++;
        $display("FAIL directed_const%0d got or=%h not=%h exp or=%h not=%h",
                 i, g.o[3:0], g.n[7:0], ot[i], nt[i]);
      end
    end
  endtask

  task automatic test_hold();
    r_t e, g;
    for (int c = 0; c < 3; c++) begin
      iv4 = 1'b0;
      a4 = 4'(c + 9);
      b4 = 4'(c * 3 + 1);
      @(posedge clk); #1;
      e = last4;
      e.v = 1'b0;
      g = obs4();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL hold%0d got=%h exp=%h", c, g, e);
      end
    end
  endtask

  task automatic test_reset_override();
    r_t e, g;
    rst_n = 1'b0;
    iv4 = 1'b1; a4 = 4'hf; b4 = 4'h0;
    @(posedge clk); #1;
    g = obs4();
    checks++;
    if (g !== r_t'(0)) begin
      errors++;
      $display("FAIL reset_override got=%h exp=0", g);
    end
    last4 = '0;
    last8 = '0;
    rst_n = 1'b1;
    a4 = 4'h3; b4 = 4'h4;
    q4.push_back(model(4, 8'h03, 8'h04));
    @(posedge clk); #1;
    e = q4.pop_front();
    last4 = e;
    g = obs4();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL first_after_reset got=%h exp=%h", g, e);
    end
    iv4 = 1'b0;
  endtask

  task automatic test_random();
    r_t e, g;
    logic p4, p8;
    for (int c = 0; c < 1200; c++) begin
      iv4 = 1'($urandom_range(0, 1));
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      iv8 = 1'($urandom_range(0, 1));
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (c % 97 == 5) begin
        a4 = 4'h0; b4 = 4'h0; a8 = 8'h00; b8 = 8'h00;
      end
      if (iv4) q4.push_back(model(4, {4'h0, a4}, {4'h0, b4}));
      if (iv8) q8.push_back(model(8, a8, b8));
      p4 = iv4;
      p8 = iv8;
      @(posedge clk); #1;
      if (p4 && q4.size() > 0) begin
        e = q4.pop_front();
        last4 = e;
      end else begin
        e = last4;
        e.v = 1'b0;
      end
      g = obs4();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rand_w4 cyc%0d got=%h exp=%h", c, g, e);
      end
      if (p8 && q8.size() > 0) begin
        e = q8.pop_front();
        last8 = e;
      end else begin
        e = last8;
        e.v = 1'b0;
      end
      g = obs8();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rand_w8 cyc%0d got=%h exp=%h", c, g, e);
      end
    end
    iv4 = 1'b0;
    iv8 = 1'b0;
    checks++;
    if (q4.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", q4.size(), q8.size());
    end
  endtask

  initial begin
    rst_n = 1'b1;
    iv4 = 1'b0; a4 = '0; b4 = '0;
    iv8 = 1'b0; a8 = '0; b8 = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold();
    test_reset_override();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector.md
VECTOR -- requirements
Module: vector

Interface
- REQ-001: Parameter WIDTH, default 4, SHALL set the bit width of each operand (legal range 1..32).
- REQ-002: clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
- REQ-003: rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
- REQ-004: in_valid  input  1  SHALL qualify a and b; high means the operands are to be captured this cycle.
- REQ-005: a  input  WIDTH  SHALL be operand A.
- REQ-006: b  input  WIDTH  SHALL be operand B.
- REQ-007: out_valid  output  1  SHALL mark the cycle in which the result outputs carry a newly captured result.
- REQ-008: a_bitwise_or_b  output  WIDTH  SHALL carry the per-bit OR of a and b.
- REQ-009: a_logical_or_b  output  1  SHALL be 1 iff a or b is nonzero.
- REQ-010: a_reduction_or  output  1  SHALL be the OR of all bits of a.
- REQ-011: b_reduction_or  output  1  SHALL be the OR of all bits of b.
- REQ-012: not_a_not_b  output  2*WIDTH  SHALL carry the inverse of b in the upper WIDTH bits and the inverse of a in the lower WIDTH bits.

Function
- REQ-013: All outputs SHALL be registered; a result SHALL appear exactly 1 clk cycle after the edge that captures in_valid=1 and the operands.
- REQ-014: On a clock edge with in_valid=1 and rst_n=1, all result registers SHALL load the functions of REQ-008..REQ-012 computed from the a and b values present at that edge.
- REQ-015: On a clock edge with in_valid=0 and rst_n=1, the result registers SHALL hold their previous values.
- REQ-016: out_valid SHALL be a registered copy of in_valid, so it is high for exactly one cycle per accepted input.
- REQ-017: Back-to-back in_valid=1 SHALL be accepted every cycle with no bubbles.
- REQ-018: a_logical_or_b SHALL equal a_reduction_or OR b_reduction_or for every accepted input.
- REQ-019: No arithmetic carries SHALL occur; each output bit SHALL depend only on the operand bits defined above.
- REQ-020: The block SHALL contain no combinational path from any input to any output.

Reset
- REQ-021: While rst_n=0 at a clock edge, out_valid and all result outputs (including not_a_not_b) SHALL be set to 0, regardless of in_valid.
- REQ-022: Reset SHALL override a simultaneous in_valid=1; that input SHALL be discarded.
- REQ-023: After rst_n returns to 1, the first in_valid=1 SHALL produce a result on the following cycle with no extra latency.
- REQ-024: Before the first clock edge with rst_n=0, output values SHALL be undefined; the bench checks outputs only after a reset edge has occurred.

Verification
- REQ-025: Reset, then a=0000, b=0000, in_valid=1 -> next cycle: out_valid=1, or=0000, logical=0, ra=0, rb=0, not_a_not_b=11111111.
- REQ-026: Send a=0000 b=0011 -> or=0011, logical=1, ra=0, rb=1, not=11001111. Then send a=0101 b=0000 -> or=0101, logical=1, ra=1, rb=0, not=11111010.
- REQ-027: Send back to back a=0101 b=0011 -> or=0111, logical 1, ra 1, rb 1, not=11001010. Then a=0101 b=1010 -> or=1111, not=01011010. Then a=1111 b=1111 -> or=1111, not=00000000. out_valid SHALL stay high for all three cycles.
- REQ-028: After a result, drop in_valid and change a/b -> out_valid=0 the next cycle and all result outputs unchanged.
- REQ-029: Assert rst_n=0 together with in_valid=1 and a=1111 -> next cycle all outputs 0.
- REQ-030: Run random a/b with random in_valid over at least 1000 cycles -> every out_valid cycle matches a reference model of REQ-008..REQ-012; repeat with WIDTH=8.
